// File: rtl/sm_fifo_pair_if.sv
// ---------------------------------------------------------------------------
// sm_fifo_pair_if
//   Bundles every data/handshake/status signal between one PIO state machine
//   FIFO pair and its two users: the CPU register block and the state machine.
//   Clock and reset are deliberately kept outside the bundle and travel as
//   plain ports on the FIFO module.
//
//   Signal summary (direction as seen by the FIFO, i.e. the slave modport):
//     join_tx, join_rx        in   storage join mode select
//     cpu_tx_we/cpu_tx_wdata  in   CPU push into TX
//     cpu_rx_re               in   CPU pop from RX
//     cpu_rx_rdata            out  RX head word (show-ahead)
//     sm_pull                 in   machine pop from TX
//     sm_tx_data              out  TX head word (show-ahead)
//     sm_push/sm_rx_data      in   machine push into RX
//     tx_empty/tx_full        out  TX status
//     rx_empty/rx_full        out  RX status
//     tx_level/rx_level       out  occupancy, $clog2(2*DEPTH)+1 bits
//     flags                   out  sticky {rxstall, txstall, rxunder, txover}
//     flag_clr                in   write-1-to-clear mask for flags
//
//   master: the side driving strobes (register block / machine / testbench)
//   slave : the FIFO pair itself
// ---------------------------------------------------------------------------
interface sm_fifo_pair_if #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
);

   localparam int LW = $clog2(2 * DEPTH) + 1;

   logic             join_tx;
   logic             join_rx;
   logic             cpu_tx_we;
   logic [WIDTH-1:0] cpu_tx_wdata;
   logic             cpu_rx_re;
   logic [WIDTH-1:0] cpu_rx_rdata;
   logic             sm_pull;
   logic [WIDTH-1:0] sm_tx_data;
   logic             sm_push;
   logic [WIDTH-1:0] sm_rx_data;
   logic             tx_empty;
   logic             tx_full;
   logic             rx_empty;
   logic             rx_full;
   logic [LW-1:0]    tx_level;
   logic [LW-1:0]    rx_level;
   logic [3:0]       flags;
   logic [3:0]       flag_clr;

   // The user side drives strobes, data and configuration, and observes
   // the head words and status.
   modport master (
      output join_tx, join_rx,
      output cpu_tx_we, cpu_tx_wdata, cpu_rx_re,
      output sm_pull, sm_push, sm_rx_data,
      output flag_clr,
      input  cpu_rx_rdata, sm_tx_data,
      input  tx_empty, tx_full, rx_empty, rx_full,
      input  tx_level, rx_level, flags
   );

   // The FIFO pair consumes strobes and produces heads and status.
   modport slave (
      input  join_tx, join_rx,
      input  cpu_tx_we, cpu_tx_wdata, cpu_rx_re,
      input  sm_pull, sm_push, sm_rx_data,
      input  flag_clr,
      output cpu_rx_rdata, sm_tx_data,
      output tx_empty, tx_full, rx_empty, rx_full,
      output tx_level, rx_level, flags
   );

endinterface

// File: rtl/sm_fifo_pair.sv
// ---------------------------------------------------------------------------
// sm_fifo_pair
//   TX/RX FIFO pair for one PIO state machine.
//     TX: CPU pushes (cpu_tx_we), machine pops (sm_pull), head -> sm_tx_data.
//     RX: machine pushes (sm_push), CPU pops (cpu_rx_re), head -> cpu_rx_rdata.
//   Both directions share one 2*DEPTH x WIDTH storage array. Unjoined, TX owns
//   entries 0..DEPTH-1 and RX owns DEPTH..2*DEPTH-1. With join_tx (or join_rx)
//   the chosen direction owns all 2*DEPTH entries and the other is disabled;
//   with both joins set, both directions are disabled.
//
//   Ports:
//     clk    in  clock
//     reset  in  synchronous, active-high
//     bus    sm_fifo_pair_if.slave: strobes, data, status, levels, flags
//
//   Parameters:
//     DEPTH  entries per direction when unjoined (power of 2, >= 2)
//     WIDTH  data word width
// ---------------------------------------------------------------------------
module sm_fifo_pair #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input logic           clk,
   input logic           reset,
   sm_fifo_pair_if.slave bus
);

   localparam int AW = $clog2(2 * DEPTH);
   localparam int LW = AW + 1;

   localparam logic [LW-1:0] CAP_HALF  = LW'(DEPTH);
   localparam logic [LW-1:0] CAP_WHOLE = LW'(2 * DEPTH);
   localparam logic [LW-1:0] CAP_NONE  = '0;
   localparam logic [AW-1:0] RX_BASE   = AW'(DEPTH);

   // Storage shared by both directions; never reset.
   logic [WIDTH-1:0] mem_q [2*DEPTH];

   logic [AW-1:0] txWrPtr_q, txWrPtr_d;
   logic [AW-1:0] txRdPtr_q, txRdPtr_d;
   logic [AW-1:0] rxWrPtr_q, rxWrPtr_d;
   logic [AW-1:0] rxRdPtr_q, rxRdPtr_d;
   logic [LW-1:0] txLevel_q, txLevel_d;
   logic [LW-1:0] rxLevel_q, rxLevel_d;
   logic [3:0]    flags_q,   flags_d;
   logic [1:0]    joinPrev_q;

   logic [LW-1:0] txCap;
   logic [LW-1:0] rxCap;
   logic [AW-1:0] rxBase;
   logic [AW-1:0] rxWrAddr;
   logic [AW-1:0] rxRdAddr;
   logic          joinChanged;
   logic          txEmpty, txFull, rxEmpty, rxFull;
   logic          txPush, txPop, rxPush, rxPop;
   logic [3:0]    flagSet;

   // Advance a pointer within a ring of 'cap' entries. Wrapping at cap-1
   // rather than at the natural power-of-two boundary keeps the ring gap-free
   // whichever capacity the current join mode gives.
   function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] ptr,
                                             input logic [LW-1:0] cap);
      logic [AW-1:0] res;
      if ({1'b0, ptr} == (cap - LW'(1))) begin
         res = '0;
      end else begin
         res = ptr + AW'(1);
      end
      return res;
   endfunction

   // Capacity and RX placement for the current join mode. A joined direction
   // takes the whole array; the other gets zero capacity and is disabled.
   // Both joins together leave nothing enabled.
   always_comb begin
      txCap  = CAP_HALF;
      rxCap  = CAP_HALF;
      rxBase = RX_BASE;
      if (bus.join_tx || bus.join_rx) begin
         txCap = CAP_NONE;
         rxCap = CAP_NONE;
         if (bus.join_tx && !bus.join_rx) begin
            txCap = CAP_WHOLE;
         end
         if (bus.join_rx && !bus.join_tx) begin
            rxCap  = CAP_WHOLE;
            rxBase = '0;
         end
      end
   end

   // Status derived from the registered levels. A zero-capacity direction
   // reads as both empty and full so every strobe to it is rejected. The
   // '>=' on full also covers the single flush cycle after a mode change,
   // where an old level may exceed the new capacity.
   always_comb begin
      txEmpty = (txCap == CAP_NONE) || (txLevel_q == '0);
      txFull  = (txCap == CAP_NONE) || (txLevel_q >= txCap);
      rxEmpty = (rxCap == CAP_NONE) || (rxLevel_q == '0);
      rxFull  = (rxCap == CAP_NONE) || (rxLevel_q >= rxCap);
   end

   // Accept/reject decisions. Status is sampled at the start of the cycle,
   // so a push into a full FIFO loses to a simultaneous pop and a pop from an
   // empty FIFO loses to a simultaneous push, without any extra arbitration.
   // Every rejected strobe raises its sticky error flag.
   always_comb begin
      txPush  = bus.cpu_tx_we & ~txFull;
      txPop   = bus.sm_pull   & ~txEmpty;
      rxPush  = bus.sm_push   & ~rxFull;
      rxPop   = bus.cpu_rx_re & ~rxEmpty;
      flagSet = {bus.sm_push   & ~rxPush,
                 bus.sm_pull   & ~txPop,
                 bus.cpu_rx_re & ~rxPop,
                 bus.cpu_tx_we & ~txPush};
   end

   // A join-mode change is detected against last cycle's registered mode.
   // The flush it triggers discards both FIFOs because their storage layout
   // is no longer valid under the new mode.
   always_comb begin
      joinChanged = ({bus.join_tx, bus.join_rx} != joinPrev_q);
   end

   // Next-state for pointers, levels and flags. A new flag set wins over a
   // coincident clear so no error event can be lost.
   always_comb begin
      txWrPtr_d = txWrPtr_q;
      txRdPtr_d = txRdPtr_q;
      rxWrPtr_d = rxWrPtr_q;
      rxRdPtr_d = rxRdPtr_q;
      txLevel_d = txLevel_q;
      rxLevel_d = rxLevel_q;
      flags_d   = (flags_q & ~bus.flag_clr) | flagSet;

      if (txPush) begin
         txWrPtr_d = nextPtr(txWrPtr_q, txCap);
      end
      if (txPop) begin
         txRdPtr_d = nextPtr(txRdPtr_q, txCap);
      end
      if (rxPush) begin
         rxWrPtr_d = nextPtr(rxWrPtr_q, rxCap);
      end
      if (rxPop) begin
         rxRdPtr_d = nextPtr(rxRdPtr_q, rxCap);
      end

      case ({txPush, txPop})
         2'b10:   txLevel_d = txLevel_q + LW'(1);
         2'b01:   txLevel_d = txLevel_q - LW'(1);
         default: txLevel_d = txLevel_q;
      endcase
      case ({rxPush, rxPop})
         2'b10:   rxLevel_d = rxLevel_q + LW'(1);
         2'b01:   rxLevel_d = rxLevel_q - LW'(1);
         default: rxLevel_d = rxLevel_q;
      endcase

      if (joinChanged) begin
         txWrPtr_d = '0;
         txRdPtr_d = '0;
         rxWrPtr_d = '0;
         rxRdPtr_d = '0;
         txLevel_d = '0;
         rxLevel_d = '0;
      end
   end

   // State registers. The join-mode history is loaded from the live inputs
   // during reset so that leaving reset never looks like a mode change.
   always_ff @(posedge clk) begin
      if (reset) begin
         txWrPtr_q  <= '0;
         txRdPtr_q  <= '0;
         rxWrPtr_q  <= '0;
         rxRdPtr_q  <= '0;
         txLevel_q  <= '0;
         rxLevel_q  <= '0;
         flags_q    <= '0;
         joinPrev_q <= {bus.join_tx, bus.join_rx};
      end else begin
         txWrPtr_q  <= txWrPtr_d;
         txRdPtr_q  <= txRdPtr_d;
         rxWrPtr_q  <= rxWrPtr_d;
         rxRdPtr_q  <= rxRdPtr_d;
         txLevel_q  <= txLevel_d;
         rxLevel_q  <= rxLevel_d;
         flags_q    <= flags_d;
         joinPrev_q <= {bus.join_tx, bus.join_rx};
      end
   end

   // RX addresses are offset into the upper half unless RX owns the whole
   // array. TX always starts at entry 0, so its pointers are its addresses.
   always_comb begin
      rxWrAddr = rxBase + rxWrPtr_q;
      rxRdAddr = rxBase + rxRdPtr_q;
   end

   // Storage writes. In unjoined mode TX and RX live in disjoint halves, and
   // in joined mode only one direction can push, so the two writes never hit
   // the same entry. Writes are suppressed in reset so strobes there are inert.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (txPush) begin
            mem_q[txWrPtr_q] <= bus.cpu_tx_wdata;
         end
         if (rxPush) begin
            mem_q[rxWrAddr] <= bus.sm_rx_data;
         end
      end
   end

   // Show-ahead heads and status outputs. A disabled direction reports a
   // level of zero regardless of any stale internal count.
   always_comb begin
      bus.sm_tx_data   = mem_q[txRdPtr_q];
      bus.cpu_rx_rdata = mem_q[rxRdAddr];
      bus.tx_empty     = txEmpty;
      bus.tx_full      = txFull;
      bus.rx_empty     = rxEmpty;
      bus.rx_full      = rxFull;
      bus.tx_level     = (txCap == CAP_NONE) ? '0 : txLevel_q;
      bus.rx_level     = (rxCap == CAP_NONE) ? '0 : rxLevel_q;
      bus.flags        = flags_q;
   end

endmodule
